// File: rtl/addsub_arbiter.sv
// addsub_arbiter
// Two-requester front end for a single shared WIDTH-bit add/subtract unit.
// A request seen in IDLE is granted (round-robin or fixed priority), its
// operands are captured, the sum/difference is registered in EXEC, and the
// owning requester gets a one-cycle done pulse in DONE.
// Result and flags hold until the next EXEC.

module addsub_arbiter #(
    parameter int WIDTH = 4,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [1:0]       gnt,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res_s,
    output logic             res_c,
    output logic             res_v,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Registered state
    state_t             state_r;
    logic               sel_r;     // 0 = requester 0 owns the datapath, 1 = requester 1
    logic               last_r;    // requester served most recently (round-robin pointer)
    logic               op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [1:0]         gnt_r;
    logic               done0_r;
    logic               done1_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic               ovf_r;
    logic               busy_r;

    // Next-state values
    state_t             state_nx_s;
    logic               sel_nx_s;
    logic               last_nx_s;
    logic               op_nx_s;
    logic [WIDTH-1:0]   a_nx_s;
    logic [WIDTH-1:0]   b_nx_s;
    logic [1:0]         gnt_nx_s;
    logic               done0_nx_s;
    logic               done1_nx_s;
    logic [WIDTH-1:0]   sum_nx_s;
    logic               carry_nx_s;
    logic               ovf_nx_s;
    logic               busy_nx_s;

    // Arbitration and datapath signals
    logic               take_s;
    logic               win_s;
    logic [WIDTH-1:0]   b_eff_s;
    logic [WIDTH:0]     add_s;
    logic               c_into_msb_s;
    logic               c_out_s;

    // Pick a winner among the currently raised requests
    always_comb begin
        take_s = 1'b0;
        win_s  = 1'b0;
        if (req0 && req1) begin
            take_s = 1'b1;
            if (FAIR) begin
                win_s = ~last_r;
            end else begin
                win_s = 1'b0;
            end
        end else if (req0) begin
            take_s = 1'b1;
            win_s  = 1'b0;
        end else if (req1) begin
            take_s = 1'b1;
            win_s  = 1'b1;
        end else begin
            take_s = 1'b0;
            win_s  = 1'b0;
        end
    end

    // The one shared adder: subtraction is A + ~B + 1; carry into the MSB is
    // recovered from the MSB sum bit so only a single carry chain is built
    always_comb begin
        b_eff_s = b_r;
        if (op_r) begin
            b_eff_s = ~b_r;
        end else begin
            b_eff_s = b_r;
        end
        add_s        = {1'b0, a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, op_r};
        c_out_s      = add_s[WIDTH];
        c_into_msb_s = a_r[WIDTH-1] ^ b_eff_s[WIDTH-1] ^ add_s[WIDTH-1];
    end

    // Next-state and next-output logic of the IDLE/EXEC/DONE sequencer
    always_comb begin
        state_nx_s = state_r;
        sel_nx_s   = sel_r;
        last_nx_s  = last_r;
        op_nx_s    = op_r;
        a_nx_s     = a_r;
        b_nx_s     = b_r;
        gnt_nx_s   = gnt_r;
        done0_nx_s = 1'b0;
        done1_nx_s = 1'b0;
        sum_nx_s   = sum_r;
        carry_nx_s = carry_r;
        ovf_nx_s   = ovf_r;
        busy_nx_s  = busy_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    state_nx_s = EXEC;
                    sel_nx_s   = win_s;
                    busy_nx_s  = 1'b1;
                    if (win_s) begin
                        op_nx_s  = op1;
                        a_nx_s   = a1;
                        b_nx_s   = b1;
                        gnt_nx_s = 2'b10;
                    end else begin
                        op_nx_s  = op0;
                        a_nx_s   = a0;
                        b_nx_s   = b0;
                        gnt_nx_s = 2'b01;
                    end
                end else begin
                    state_nx_s = IDLE;
                    gnt_nx_s   = 2'b00;
                    busy_nx_s  = 1'b0;
                end
            end
            EXEC: begin
                state_nx_s = DONE;
                sum_nx_s   = add_s[WIDTH-1:0];
                carry_nx_s = c_out_s;
                ovf_nx_s   = c_into_msb_s ^ c_out_s;
                done0_nx_s = ~sel_r;
                done1_nx_s = sel_r;
            end
            DONE: begin
                state_nx_s = IDLE;
                gnt_nx_s   = 2'b00;
                busy_nx_s  = 1'b0;
                if (FAIR) begin
                    last_nx_s = sel_r;
                end else begin
                    last_nx_s = last_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
                gnt_nx_s   = 2'b00;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // State, captured operands and all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            sel_r   <= 1'b0;
            last_r  <= 1'b1;
            op_r    <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            gnt_r   <= 2'b00;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            sel_r   <= sel_nx_s;
            last_r  <= last_nx_s;
            op_r    <= op_nx_s;
            a_r     <= a_nx_s;
            b_r     <= b_nx_s;
            gnt_r   <= gnt_nx_s;
            done0_r <= done0_nx_s;
            done1_r <= done1_nx_s;
            sum_r   <= sum_nx_s;
            carry_r <= carry_nx_s;
            ovf_r   <= ovf_nx_s;
            busy_r  <= busy_nx_s;
        end
    end

    assign gnt   = gnt_r;
    assign done0 = done0_r;
    assign done1 = done1_r;
    assign res_s = sum_r;
    assign res_c = carry_r;
    assign res_v = ovf_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: a round-robin instance and a
// fixed-priority instance share operands but have separate request lines.
// Stimulus pushes expected results; negedge monitors pop and compare.

module tb_addsub_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, op0, req1, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         req0_f, req1_f;

    logic [1:0]   rr_gnt, fp_gnt;
    logic         rr_done0, rr_done1, fp_done0, fp_done1;
    logic [W-1:0] rr_res, fp_res;
    logic         rr_c, rr_v, fp_c, fp_v, rr_busy, fp_busy;

    addsub_arbiter #(.WIDTH(W), .FAIR(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt(rr_gnt), .done0(rr_done0), .done1(rr_done1),
        .res_s(rr_res), .res_c(rr_c), .res_v(rr_v), .busy(rr_busy)
    );

    addsub_arbiter #(.WIDTH(W), .FAIR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_f), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1_f), .op1(op1), .a1(a1), .b1(b1),
        .gnt(fp_gnt), .done0(fp_done0), .done1(fp_done1),
        .res_s(fp_res), .res_c(fp_c), .res_v(fp_v), .busy(fp_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic         who;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic [31:0]  at;
    } exp_t;

    exp_t q_rr[$];
    exp_t q_fp[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rr gnt"},   {30'd0, rr_gnt}, 32'd0);
        check({tag, " rr done"},  {30'd0, rr_done1, rr_done0}, 32'd0);
        check({tag, " rr res"},   {28'd0, rr_res}, 32'd0);
        check({tag, " rr cv"},    {30'd0, rr_c, rr_v}, 32'd0);
        check({tag, " rr busy"},  {31'd0, rr_busy}, 32'd0);
        check({tag, " fp gnt"},   {30'd0, fp_gnt}, 32'd0);
        check({tag, " fp done"},  {30'd0, fp_done1, fp_done0}, 32'd0);
        check({tag, " fp res"},   {28'd0, fp_res}, 32'd0);
        check({tag, " fp cv"},    {30'd0, fp_c, fp_v}, 32'd0);
        check({tag, " fp busy"},  {31'd0, fp_busy}, 32'd0);
    endtask

    // Round-robin instance monitor
    always @(negedge clk) begin
        exp_t e;
        if (rr_done0 || rr_done1) begin
            if (q_rr.size() == 0) begin
                check("rr unexpected done", {30'd0, rr_done1, rr_done0}, 32'd0);
            end else begin
                e = q_rr.pop_front();
                check("rr done who", {30'd0, rr_done1, rr_done0}, e.who ? 32'd2 : 32'd1);
                check("rr res_s",    {28'd0, rr_res}, {28'd0, e.s});
                check("rr res_c",    {31'd0, rr_c}, {31'd0, e.c});
                check("rr res_v",    {31'd0, rr_v}, {31'd0, e.v});
                check("rr done cycle", cyc, e.at);
            end
        end
    end

    // Fixed-priority instance monitor
    always @(negedge clk) begin
        exp_t e;
        if (fp_done0 || fp_done1) begin
            if (q_fp.size() == 0) begin
                check("fp unexpected done", {30'd0, fp_done1, fp_done0}, 32'd0);
            end else begin
                e = q_fp.pop_front();
                check("fp done who", {30'd0, fp_done1, fp_done0}, e.who ? 32'd2 : 32'd1);
                check("fp res_s",    {28'd0, fp_res}, {28'd0, e.s});
                check("fp res_c",    {31'd0, fp_c}, {31'd0, e.c});
                check("fp res_v",    {31'd0, fp_v}, {31'd0, e.v});
                check("fp done cycle", cyc, e.at);
            end
        end
    end

    // One transaction on the round-robin instance; optionally disturb the
    // requester's inputs (flip A and op, drop req) during EXEC.
    task automatic issue(input logic who, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] s,
                         input logic c, input logic v, input bit mangle);
        exp_t e;
        if (!who) begin
            op0 = op; a0 = a; b0 = b; req0 = 1'b1;
        end else begin
            op1 = op; a1 = a; b1 = b; req1 = 1'b1;
        end
        e = '{who: who, s: s, c: c, v: v, at: cyc + 2};
        q_rr.push_back(e);
        @(posedge clk); #1;
        if (mangle) begin
            if (!who) begin
                a0 = ~a0; op0 = ~op0; req0 = 1'b0;
            end else begin
                a1 = ~a1; op1 = ~op1; req1 = 1'b0;
            end
        end
        @(negedge clk);
        check("gnt in EXEC", {30'd0, rr_gnt}, who ? 32'd2 : 32'd1);
        check("busy in EXEC", {31'd0, rr_busy}, 32'd1);
        @(negedge clk);
        check("gnt in DONE", {30'd0, rr_gnt}, who ? 32'd2 : 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        check("gnt after DONE", {30'd0, rr_gnt}, 32'd0);
        check("busy after DONE", {31'd0, rr_busy}, 32'd0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        req0 = 1'b0; op0 = 1'b0; a0 = 4'd0; b0 = 4'd0;
        req1 = 1'b0; op1 = 1'b0; a1 = 4'd0; b1 = 4'd0;
        req0_f = 1'b0; req1_f = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add with signed overflow
        issue(1'b0, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0);
        // Subtract with and without borrow
        issue(1'b1, 1'b1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 4'b0101, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
        // Carry wrap, then carry plus overflow
        issue(1'b0, 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0);
        // Operand/op change and request drop during EXEC
        issue(1'b0, 1'b0, 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b1);

        // Reset while requester 1 is in EXEC: no done1 may follow
        op1 = 1'b0; a1 = 4'b0011; b1 = 4'b0100; req1 = 1'b1;
        @(posedge clk); #1;
        check("busy before reset", {31'd0, rr_busy}, 32'd1);
        rst_n = 1'b0;
        req1 = 1'b0;
        #1;
        check_zero("mid-EXEC reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Both requests held for four transactions on both instances
        op0 = 1'b0; a0 = 4'b0001; b0 = 4'b0001;
        op1 = 1'b1; a1 = 4'b0100; b1 = 4'b0001;
        req0 = 1'b1; req1 = 1'b1; req0_f = 1'b1; req1_f = 1'b1;
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                q_rr.push_back('{who: 1'b0, s: 4'b0010, c: 1'b0, v: 1'b0, at: base + 2 + 3 * k});
            end else begin
                q_rr.push_back('{who: 1'b1, s: 4'b0011, c: 1'b1, v: 1'b0, at: base + 2 + 3 * k});
            end
            q_fp.push_back('{who: 1'b0, s: 4'b0010, c: 1'b0, v: 1'b0, at: base + 2 + 3 * k});
        end
        repeat (11) @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; req0_f = 1'b0; req1_f = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rr outstanding", q_rr.size(), 32'd0);
        check("fp outstanding", q_fp.size(), 32'd0);
        check("rr idle at end", {31'd0, rr_busy}, 32'd0);
        check("fp idle at end", {31'd0, fp_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one WIDTH-bit two's-complement add/subtract datapath between two requesters.
- Each requester presents an operation code and two operands.
- The block picks one requester, either round-robin or fixed priority, and latches its operands. It then runs the datapath and returns the registered sum/difference and the C and V flags with a one-cycle done pulse.
- It sits between client FSMs and the single shared adder/subtractor, so the adder/subtractor is instantiated once in the design.

Parameters:
- WIDTH, 4, operand and result width in bits.
- FAIR, 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 request, level.
- op0  input  1  requester 0 operation: 0 = A+B, 1 = A-B.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1, op1, a1, b1  input  1/1/WIDTH/WIDTH  requester 1, same meanings as requester 0.
- gnt  output  2  one-hot grant; held from latch until done.
- done0  output  1  one-cycle pulse: requester 0 result valid.
- done1  output  1  one-cycle pulse: requester 1 result valid.
- res_s  output  WIDTH  result, shared by both requesters.
- res_c  output  1  carry out of the MSB.
- res_v  output  1  signed overflow.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - Asserting rst_n low at any time forces state to IDLE.
  - gnt, done0, done1, res_s, res_c, res_v and busy all go to 0.
  - The round-robin pointer `last` goes to 1, so requester 0 wins the first tie.
  - Any in-flight operation is abandoned with no done pulse.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one reqN high: grant N.
  - Both high, FAIR=1: grant the requester that is not `last`.
  - Both high, FAIR=0: grant requester 0.
  - On a grant, latch opN, aN and bN into internal registers, set gnt one-hot, and go to EXEC.
- EXEC:
  - The datapath computes from the latched registers only; operand or op changes at the inputs after the grant cycle are ignored.
  - Register the result into res_s, res_c and res_v. Go to DONE.
- DONE:
  - Assert doneN for exactly this cycle. If FAIR=1, set `last` = N.
  - Clear gnt at the transition back to IDLE.
- Latency: req sampled in cycle t (IDLE) → done high in cycle t+2. Next grant earliest at t+3. Maximum throughput is 1 operation per 3 cycles.
- Arithmetic:
  - op=0: {C,S} = A + B.
  - op=1: {C,S} = A + ~B + 1, so C=1 means no borrow (A ≥ B unsigned).
  - V = carry into MSB XOR carry out of MSB.
  - Results are modulo 2^WIDTH.
- Result hold: res_s, res_c and res_v hold their values until the next EXEC. They stay valid after done.
- Handshake:
  - A requester holds reqN high until it sees doneN, and drops it on the following cycle.
  - If reqN is still high in the IDLE cycle after DONE, it is a new request.
  - Dropping reqN after the grant does not cancel the operation; the result and done are still produced.
- Simultaneous events:
  - A request arriving during EXEC or DONE is not seen until IDLE.
  - With FAIR=1 and both requests held continuously, grants alternate 0,1,0,1...
  - The losing requester waits at most one transaction.

Test Plan:
- Reset mid-EXEC: reset while requester 1 is in EXEC → all outputs 0, no done1; the next tie is granted to requester 0.
- Single request, add: req0=1, op0=0, a0=0111, b0=0001 → done0 at t+2; res_s=1000, res_c=0, res_v=1; gnt=01 during t+1..t+2.
- Subtract: op1=1, a1=0011, b1=0101 → res_s=1110, res_c=0, res_v=0. Then a1=0101, b1=0011 → res_s=0010, res_c=1, res_v=0.
- Carry wrap: op0=0, a0=1111, b0=0001 → res_s=0000, res_c=1, res_v=0. With a0=1000, b0=1000 → res_s=0000, res_c=1, res_v=1.
- Round-robin: FAIR=1, req0 and req1 held high for 4 transactions → done pulses ordered 0,1,0,1, each 3 cycles apart. With FAIR=0 the same stimulus gives 0,0,0,0.
- Operand change and drop:
  - Change a0 the cycle after the grant → the result uses the latched value.
  - Drop req0 in EXEC → done0 still pulses with the correct result.
